// File: rtl/multibit_sync_stable_n_pkg.sv
// Shared types and Gray-code helpers for the multi-bit stability synchronizer.
// gray2bin/bin2gray work on a fixed maximum width; callers zero-extend and truncate.
package msync_pkg;

  localparam int MSYNC_MIN_STAGES = 2;
  localparam int MSYNC_MAX_W      = 256;

  typedef enum logic {
    MS_IDLE   = 1'b0,
    MS_SETTLE = 1'b1
  } msync_state_e;

  // Leading zeros do not disturb the prefix XOR, so narrower words convert correctly.
  function automatic logic [MSYNC_MAX_W-1:0] gray2bin(input logic [MSYNC_MAX_W-1:0] g);
    logic [MSYNC_MAX_W-1:0] b;
    b[MSYNC_MAX_W-1] = g[MSYNC_MAX_W-1];
    for (int i = MSYNC_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MSYNC_MAX_W-1:0] bin2gray(input logic [MSYNC_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/multibit_sync_stable_n_if.sv
// Bus bundle for the multi-bit synchronizer: async input word and published outputs.
// slave = synchronizer side, master = producer/consumer side.
interface msync_if #(
  parameter int DW = 32
);
  logic [DW-1:0] async_data_i;
  logic [DW-1:0] sync_data_o;
  logic          sync_upd_o;
  logic          busy_o;

  modport slave (
    input  async_data_i,
    output sync_data_o,
    output sync_upd_o,
    output busy_o
  );

  modport master (
    output async_data_i,
    input  sync_data_o,
    input  sync_upd_o,
    input  busy_o
  );
endinterface

// File: rtl/multibit_sync_stable_n_sync_chain.sv
// Single-bit synchronizer: STAGES flops in series on clki, async reset to 0.
module sync_chain_n #(
  parameter int STAGES = 2
) (
  input  logic clki,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] s_q;

  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      s_q <= '0;
    end else begin
      s_q <= {s_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = s_q[STAGES-1];

endmodule

// File: rtl/multibit_sync_stable_n.sv
// Multi-bit synchronizer with stability qualifier and one-cycle update strobe.
// Build option MSYNC_GRAY_DECODE_EN: input is Gray-coded, published word is binary.
module multibit_sync_stable_n
  import msync_pkg::*;
#(
  parameter int DW         = 32,
  parameter int STAGES     = 2,
  parameter int STABLE_CYC = 2
) (
  input  logic   clki,
  input  logic   rstn,
  msync_if.slave bus
);

  localparam int            CW      = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

  if (STAGES < MSYNC_MIN_STAGES) begin : g_bad_stages
    $error("multibit_sync_stable_n: STAGES must be >= 2");
  end
  if (STABLE_CYC < 1) begin : g_bad_stable
    $error("multibit_sync_stable_n: STABLE_CYC must be >= 1");
  end

  logic [DW-1:0] samp;
  logic [DW-1:0] cand_q,    cand_d;
  logic [DW-1:0] data_q,    data_d;
  logic [DW-1:0] pub_raw,   pub_raw_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          qual_q,    qual_d;
  logic          upd_q;
  logic          publish;
  logic          busy;
  msync_state_e  state_q,   state_d;

  for (genvar gi = 0; gi < DW; gi++) begin : sync_chain
    sync_chain_n #(.STAGES(STAGES)) u_bit (
      .clki (clki),
      .rstn (rstn),
      .d_i  (bus.async_data_i[gi]),
      .q_o  (samp[gi])
    );
  end

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (samp != cand_q) begin
      cand_d = samp;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Qualification is registered so the publish decision never sees a half-updated candidate.
  assign qual_d    = (samp == cand_q) && (cnt_q == CNT_MAX);
  assign publish   = qual_q && (cand_q != pub_raw);
  assign pub_raw_d = publish ? cand_q : pub_raw;

`ifdef MSYNC_GRAY_DECODE_EN
  if (DW > MSYNC_MAX_W) begin : g_bad_width
    $error("multibit_sync_stable_n: DW exceeds MSYNC_MAX_W for Gray decode");
  end

  logic [DW-1:0] pub_gray_q;

  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      pub_gray_q <= '0;
    end else begin
      pub_gray_q <= pub_raw_d;
    end
  end

  assign pub_raw = pub_gray_q;
  assign data_d  = publish ? DW'(gray2bin(MSYNC_MAX_W'(cand_q))) : data_q;
`else
  assign pub_raw = data_q;
  assign data_d  = publish ? cand_q : data_q;
`endif

  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      cand_q <= '0;
      cnt_q  <= '0;
      qual_q <= 1'b0;
      data_q <= '0;
      upd_q  <= 1'b0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      qual_q <= qual_d;
      data_q <= data_d;
      upd_q  <= publish;
    end
  end

  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      state_q <= MS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE:   if (cand_d != pub_raw_d) state_d = MS_SETTLE;
      MS_SETTLE: if (cand_d == pub_raw_d) state_d = MS_IDLE;
      default:   state_d = MS_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == MS_SETTLE);
  end

  assign bus.sync_data_o = data_q;
  assign bus.sync_upd_o  = upd_q;
  assign bus.busy_o      = busy;

endmodule
